// File: rtl/pa_spsram_arb_ctrl.sv
// Controller and round-robin two-requester arbiter for a single-port SRAM macro.
// It zero-fills the array after reset and returns read data one cycle after the grant.
module pa_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int INIT_EN    = 1
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    req0_vld,
  input  logic                    req0_wr,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_be,
  output logic                    req0_gnt,
  output logic                    req0_rvld,
  output logic [DATA_WIDTH-1:0]   req0_rdata,
  input  logic                    req1_vld,
  input  logic                    req1_wr,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_be,
  output logic                    req1_gnt,
  output logic                    req1_rvld,
  output logic [DATA_WIDTH-1:0]   req1_rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_done;
  logic                  r_rr_ptr;
  logic                  r_rvld0;
  logic                  r_rvld1;
  logic                  r_rsp_sel;
  logic                  w_run;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_rd0;
  logic                  w_rd1;

  function automatic logic [DATA_WIDTH-1:0] beToWen(input logic [BE_W-1:0] be);
    logic [DATA_WIDTH-1:0] res;
    res = '1;
    for (int i = 0; i < BE_W; i++) begin
      res[8*i +: 8] = {8{~be[i]}};
    end
    return res;
  endfunction

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Round-robin: the pointer side wins a tie; after any grant it moves to the loser.
  assign w_run  = (r_state == ST_RUN);
  assign w_gnt0 = w_run && req0_vld && (!req1_vld || !r_rr_ptr);
  assign w_gnt1 = w_run && req1_vld && (!req0_vld ||  r_rr_ptr);
  assign w_rd0  = w_gnt0 && !req0_wr;
  assign w_rd1  = w_gnt1 && !req1_wr;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rr_ptr  <= 1'b0;
      r_rvld0   <= 1'b0;
      r_rvld1   <= 1'b0;
      r_rsp_sel <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_rr_ptr <= 1'b1;
      end else if (w_gnt1) begin
        r_rr_ptr <= 1'b0;
      end
      r_rvld0 <= w_rd0;
      r_rvld1 <= w_rd1;
      if (w_rd0) begin
        r_rsp_sel <= 1'b0;
      end else if (w_rd1) begin
        r_rsp_sel <= 1'b1;
      end
    end
  end

  // SRAM port drive; held idle while reset is asserted even though the FSM sits in INIT.
  always_comb begin
    sram_a    = req0_addr;
    sram_d    = req0_wdata;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    if (!cpurst_b) begin
      sram_a = '0;
    end else if (r_state == ST_INIT) begin
      sram_a    = r_init_cnt;
      sram_d    = '0;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
    end else if (w_gnt0) begin
      sram_a    = req0_addr;
      sram_d    = req0_wdata;
      sram_gwen = !req0_wr;
      sram_wen  = req0_wr ? beToWen(req0_be) : '1;
      sram_cen  = req0_wr && (req0_be == '0);
    end else if (w_gnt1) begin
      sram_a    = req1_addr;
      sram_d    = req1_wdata;
      sram_gwen = !req1_wr;
      sram_wen  = req1_wr ? beToWen(req1_be) : '1;
      sram_cen  = req1_wr && (req1_be == '0);
    end
  end

  assign req0_gnt   = w_gnt0;
  assign req1_gnt   = w_gnt1;
  assign init_done  = r_init_done;
  assign req0_rvld  = r_rvld0;
  assign req1_rvld  = r_rvld1;
  assign req0_rdata = (r_rvld0 && !r_rsp_sel) ? sram_q : '0;
  assign req1_rdata = (r_rvld1 &&  r_rsp_sel) ? sram_q : '0;

endmodule

// File: tb/tb_pa_spsram_arb_ctrl.sv
// Directed testbench for pa_spsram_arb_ctrl with a behavioural 4096x32 SRAM model.
// A vector table covers RUN-mode arbitration/writes/reads; hand sequences cover init and reset.
module tb_pa_spsram_arb_ctrl;

  logic        clk;
  logic        rstN;
  logic        req0Vld, req0Wr, req1Vld, req1Wr;
  logic [11:0] req0Addr, req1Addr;
  logic [31:0] req0Wdata, req1Wdata;
  logic [3:0]  req0Be, req1Be;
  logic        req0Gnt, req1Gnt, req0Rvld, req1Rvld;
  logic [31:0] req0Rdata, req1Rdata;
  logic        initDone;
  logic [11:0] sramA;
  logic        sramCen, sramGwen;
  logic [31:0] sramWen, sramD, sramQ;
  logic [31:0] mem [0:4095];

  int testsRun;
  int testsFailed;

  typedef struct {
    logic v0; logic w0; logic [11:0] a0; logic [31:0] d0; logic [3:0] b0;
    logic v1; logic w1; logic [11:0] a1; logic [31:0] d1; logic [3:0] b1;
    logic eg0; logic eg1; logic ecen; logic egwen; logic [31:0] ewen;
    logic chkAD; logic [11:0] ea; logic [31:0] ed;
    logic erv0; logic erv1; logic [31:0] erd0; logic [31:0] erd1;
  } vec_t;

  vec_t vecs [0:13];

  pa_spsram_arb_ctrl dut (
    .forever_cpuclk(clk),
    .cpurst_b(rstN),
    .req0_vld(req0Vld),
    .req0_wr(req0Wr),
    .req0_addr(req0Addr),
    .req0_wdata(req0Wdata),
    .req0_be(req0Be),
    .req0_gnt(req0Gnt),
    .req0_rvld(req0Rvld),
    .req0_rdata(req0Rdata),
    .req1_vld(req1Vld),
    .req1_wr(req1Wr),
    .req1_addr(req1Addr),
    .req1_wdata(req1Wdata),
    .req1_be(req1Be),
    .req1_gnt(req1Gnt),
    .req1_rvld(req1Rvld),
    .req1_rdata(req1Rdata),
    .init_done(initDone),
    .sram_a(sramA),
    .sram_cen(sramCen),
    .sram_gwen(sramGwen),
    .sram_wen(sramWen),
    .sram_d(sramD),
    .sram_q(sramQ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM macro model: per-bit active-low write mask, registered read data.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_BEEF;
    sramQ = 32'h0;
  end

  always @(posedge clk) begin
    if (!sramCen) begin
      if (!sramGwen) mem[sramA] <= (mem[sramA] & sramWen) | (sramD & ~sramWen);
      else           sramQ      <= mem[sramA];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    req0Vld = 0; req0Wr = 0; req0Addr = '0; req0Wdata = '0; req0Be = '0;
    req1Vld = 0; req1Wr = 0; req1Addr = '0; req1Wdata = '0; req1Be = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    req0Vld = v.v0; req0Wr = v.w0; req0Addr = v.a0; req0Wdata = v.d0; req0Be = v.b0;
    req1Vld = v.v1; req1Wr = v.w1; req1Addr = v.a1; req1Wdata = v.d1; req1Be = v.b1;
  endtask

  // Reset, then walk the full zero-fill with req0 asking for the port the whole time.
  task automatic doInit(input bit checkSweep);
    clearInputs();
    req0Vld = 1;
    rstN = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cen", sramCen, 1);
    checkOutput("rst_gwen", sramGwen, 1);
    checkOutput("rst_wen", sramWen, 32'hFFFF_FFFF);
    checkOutput("rst_init_done", initDone, 0);
    checkOutput("rst_rvld0", req0Rvld, 0);
    checkOutput("rst_rvld1", req1Rvld, 0);
    checkOutput("rst_gnt0", req0Gnt, 0);
    @(posedge clk);
    #1 rstN = 1;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (checkSweep) begin
        checkOutput("init_a", sramA, i);
        checkOutput("init_cen", sramCen, 0);
        checkOutput("init_gwen", sramGwen, 0);
        checkOutput("init_wen", sramWen, 0);
        checkOutput("init_d", sramD, 0);
        checkOutput("init_gnt0", req0Gnt, 0);
        checkOutput("init_done_low", initDone, 0);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("init_done_high", initDone, 1);
    checkOutput("first_run_gnt0", req0Gnt, 1);
    clearInputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rstN = 0;
    clearInputs();

    // v0 w0 a0 d0 b0 | v1 w1 a1 d1 b1 | eg0 eg1 cen gwen wen | chkAD a d | rv0 rv1 rd0 rd1
    vecs[0]  = '{1,1,12'h010,32'hA5A5_5A5A,4'b0101, 0,0,12'h000,32'h0,4'b0000, 1,0,0,0,32'hFF00_FF00, 1,12'h010,32'hA5A5_5A5A, 0,0,32'h0,32'h0};
    vecs[1]  = '{1,0,12'h010,32'h0,4'b0000, 0,0,12'h000,32'h0,4'b0000, 1,0,0,1,32'hFFFF_FFFF, 1,12'h010,32'h0, 0,0,32'h0,32'h0};
    vecs[2]  = '{1,0,12'h020,32'h0,4'b0000, 1,0,12'h030,32'h0,4'b0000, 0,1,0,1,32'hFFFF_FFFF, 1,12'h030,32'h0, 1,0,32'h00A5_005A,32'h0};
    vecs[3]  = '{1,0,12'h020,32'h0,4'b0000, 1,0,12'h030,32'h0,4'b0000, 1,0,0,1,32'hFFFF_FFFF, 1,12'h020,32'h0, 0,1,32'h0,32'h0};
    vecs[4]  = '{1,0,12'h020,32'h0,4'b0000, 1,0,12'h030,32'h0,4'b0000, 0,1,0,1,32'hFFFF_FFFF, 1,12'h030,32'h0, 1,0,32'h0,32'h0};
    vecs[5]  = '{1,0,12'h020,32'h0,4'b0000, 1,0,12'h030,32'h0,4'b0000, 1,0,0,1,32'hFFFF_FFFF, 1,12'h020,32'h0, 0,1,32'h0,32'h0};
    vecs[6]  = '{0,0,12'h000,32'h0,4'b0000, 1,1,12'h0FF,32'h1234_5678,4'b1111, 0,1,0,0,32'h0000_0000, 1,12'h0FF,32'h1234_5678, 1,0,32'h0,32'h0};
    vecs[7]  = '{0,0,12'h000,32'h0,4'b0000, 1,1,12'h100,32'hCAFE_F00D,4'b1100, 0,1,0,0,32'h0000_FFFF, 1,12'h100,32'hCAFE_F00D, 0,0,32'h0,32'h0};
    vecs[8]  = '{0,0,12'h000,32'h0,4'b0000, 1,0,12'h0FF,32'h0,4'b0000, 0,1,0,1,32'hFFFF_FFFF, 1,12'h0FF,32'h0, 0,0,32'h0,32'h0};
    vecs[9]  = '{1,0,12'h100,32'h0,4'b0000, 0,0,12'h000,32'h0,4'b0000, 1,0,0,1,32'hFFFF_FFFF, 1,12'h100,32'h0, 0,1,32'h0,32'h1234_5678};
    vecs[10] = '{0,0,12'h000,32'h0,4'b0000, 1,1,12'h0FF,32'hFFFF_FFFF,4'b0000, 0,1,1,0,32'hFFFF_FFFF, 1,12'h0FF,32'hFFFF_FFFF, 1,0,32'hCAFE_0000,32'h0};
    vecs[11] = '{0,0,12'h000,32'h0,4'b0000, 1,0,12'h0FF,32'h0,4'b0000, 0,1,0,1,32'hFFFF_FFFF, 1,12'h0FF,32'h0, 0,0,32'h0,32'h0};
    vecs[12] = '{0,0,12'h000,32'h0,4'b0000, 0,0,12'h000,32'h0,4'b0000, 0,0,1,1,32'hFFFF_FFFF, 0,12'h000,32'h0, 0,1,32'h0,32'h1234_5678};
    vecs[13] = '{0,0,12'h000,32'h0,4'b0000, 0,0,12'h000,32'h0,4'b0000, 0,0,1,1,32'hFFFF_FFFF, 0,12'h000,32'h0, 0,0,32'h0,32'h0};

    doInit(1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_gnt0", i), req0Gnt, vecs[i].eg0);
      checkOutput($sformatf("v%0d_gnt1", i), req1Gnt, vecs[i].eg1);
      checkOutput($sformatf("v%0d_cen", i), sramCen, vecs[i].ecen);
      checkOutput($sformatf("v%0d_gwen", i), sramGwen, vecs[i].egwen);
      checkOutput($sformatf("v%0d_wen", i), sramWen, vecs[i].ewen);
      if (vecs[i].chkAD) begin
        checkOutput($sformatf("v%0d_a", i), sramA, vecs[i].ea);
        checkOutput($sformatf("v%0d_d", i), sramD, vecs[i].ed);
      end
      checkOutput($sformatf("v%0d_rvld0", i), req0Rvld, vecs[i].erv0);
      checkOutput($sformatf("v%0d_rvld1", i), req1Rvld, vecs[i].erv1);
      if (vecs[i].erv0) checkOutput($sformatf("v%0d_rdata0", i), req0Rdata, vecs[i].erd0);
      if (vecs[i].erv1) checkOutput($sformatf("v%0d_rdata1", i), req1Rdata, vecs[i].erd1);
      @(posedge clk);
      #1;
    end

    // Reset part-way through init: the sweep must restart from address 0.
    rstN = 0;
    @(posedge clk);
    #1 rstN = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("midinit_a100", sramA, 100);
    #1 rstN = 0;
    #1;
    checkOutput("midinit_rst_cen", sramCen, 1);
    checkOutput("midinit_rst_done", initDone, 0);
    @(posedge clk);
    #1 rstN = 1;
    @(negedge clk);
    checkOutput("midinit_restart_a", sramA, 0);
    checkOutput("midinit_restart_cen", sramCen, 0);
    checkOutput("midinit_restart_done", initDone, 0);

    // Reset one cycle after a read grant: the pending rvld must never appear.
    doInit(0);
    req0Vld = 1; req0Wr = 0; req0Addr = 12'h010;
    @(negedge clk);
    checkOutput("midrun_gnt0", req0Gnt, 1);
    @(posedge clk);
    #1 rstN = 0;
    clearInputs();
    #1;
    checkOutput("midrun_rvld0", req0Rvld, 0);
    checkOutput("midrun_done", initDone, 0);
    checkOutput("midrun_cen", sramCen, 1);
    @(posedge clk);
    #1 rstN = 1;
    @(negedge clk);
    checkOutput("midrun_rel_rvld0", req0Rvld, 0);
    checkOutput("midrun_rel_a", sramA, 0);
    checkOutput("midrun_rel_done", initDone, 0);

    // Fresh reset favours req0, then strict alternation; a lone req1 wins every cycle.
    doInit(0);
    req0Vld = 1; req1Vld = 1; req0Addr = 12'h001; req1Addr = 12'h002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("alt%0d_gnt0", i), req0Gnt, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("alt%0d_gnt1", i), req1Gnt, (i % 2 == 1) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    req0Vld = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("solo%0d_gnt1", i), req1Gnt, 1);
      checkOutput($sformatf("solo%0d_gnt0", i), req0Gnt, 0);
      @(posedge clk);
      #1;
    end
    clearInputs();
    @(negedge clk);
    checkOutput("end_rvld1", req1Rvld, 1);
    checkOutput("end_rvld0", req0Rvld, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
